// File: rtl/exec_stage_md.sv
`default_nettype none
// ============================================================================
// exec_stage_md -- XLEN ALU + forwarding, iterative mul/div, E->M register
// Rev 1.0
// ============================================================================
module exec_stage_md #(
  parameter int XLEN  = 32,
  parameter int MD_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ValidE,
  input  logic            FlushE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RdE,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ALUResultM_back,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic            ALUSrcE,
  input  logic [3:0]      ALUControlE,
  input  logic            MdE,
  input  logic [2:0]      MdOpE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM,
  output logic            ValidM,
  output logic [XLEN-1:0] PCTargetE,
  output logic            ZeroE,
  output logic            StallE
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;

  logic [XLEN-1:0]   alu_m_q, alu_m_d;
  logic [XLEN-1:0]   wd_m_q, wd_m_d;
  logic [XLEN-1:0]   pc4_m_q, pc4_m_d;
  logic [4:0]        rd_m_q, rd_m_d;
  logic              valid_m_q, valid_m_d;

  logic [XLEN-1:0]   src_a, fwd_b, src_b, alu_res;
  logic [SW-1:0]     shamt;

  always_comb begin
    case (ForwardAE)
      2'b00:   src_a = RD1E;
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM_back;
      default: src_a = '0;
    endcase
    case (ForwardBE)
      2'b00:   fwd_b = RD2E;
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM_back;
      default: fwd_b = '0;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : fwd_b;
  assign shamt = src_b[SW-1:0];

  always_comb begin
    case (ALUControlE)
      4'd0:    alu_res = src_a + src_b;
      4'd1:    alu_res = src_a - src_b;
      4'd2:    alu_res = src_a & src_b;
      4'd3:    alu_res = src_a | src_b;
      4'd4:    alu_res = src_a ^ src_b;
      4'd5:    alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'd6:    alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      4'd7:    alu_res = src_a << shamt;
      4'd8:    alu_res = src_a >> shamt;
      4'd9:    alu_res = $unsigned($signed(src_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  assign ZeroE     = (alu_res == '0);
  assign PCTargetE = PCE + ImmExtE;

  // Operand signedness: MULH, MULHSU, DIV, REM treat A as signed; MULH, DIV, REM treat B as signed.
  logic            md_start;
  logic            sa_in, sa_q, sb_q;
  logic            a_neg_in, a_neg, b_neg;
  logic [XLEN-1:0] a_mag_in, b_mag;

  assign md_start = (MD_EN != 0) && (state_q == S_IDLE) && ValidE && MdE && !FlushE;
  assign sa_in    = (MdOpE == 3'd1) || (MdOpE == 3'd2) || (MdOpE == 3'd4) || (MdOpE == 3'd6);
  assign sa_q     = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
  assign sb_q     = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
  assign a_neg_in = sa_in && src_a[XLEN-1];
  assign a_mag_in = a_neg_in ? -src_a : src_a;
  assign a_neg    = sa_q && a_q[XLEN-1];
  assign b_neg    = sb_q && b_q[XLEN-1];
  assign b_mag    = b_neg ? -b_q : b_q;

  // acc holds {partial-product high, multiplier} for mul, {remainder, quotient} for div.
  logic [XLEN:0]     mul_sum, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_mag} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_mag};
  assign div_next = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, md_res;
  logic              b_zero;

  assign prod_fix = (a_neg ^ b_neg) ? -acc_q : acc_q;
  assign quo_fix  = (a_neg ^ b_neg) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = a_neg ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign b_zero   = (b_q == '0);

  always_comb begin
    case (op_q)
      3'd0:        md_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:        md_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:  md_res = b_zero ? '1 : quo_fix;
      default:     md_res = b_zero ? a_q : rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    pc4_d   = pc4_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (md_start) begin
          state_d = S_BUSY;
          cnt_d   = SW'(XLEN-1);
          acc_d   = {{XLEN{1'b0}}, a_mag_in};
          a_d     = src_a;
          b_d     = fwd_b;
          op_d    = MdOpE;
          rd_d    = RdE;
          pc4_d   = PCPlus4E;
        end
      end
      S_BUSY: begin
        if (FlushE) begin
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_m_d   = alu_res;
    wd_m_d    = fwd_b;
    pc4_m_d   = PCPlus4E;
    valid_m_d = ValidE && !FlushE;
    rd_m_d    = (ValidE && !FlushE) ? RdE : 5'd0;
    if ((state_q == S_DONE && FlushE) || state_q == S_BUSY || md_start) begin
      alu_m_d   = '0;
      wd_m_d    = '0;
      pc4_m_d   = '0;
      valid_m_d = 1'b0;
      rd_m_d    = 5'd0;
    end else if (state_q == S_DONE) begin
      alu_m_d   = md_res;
      wd_m_d    = b_q;
      pc4_m_d   = pc4_q;
      valid_m_d = 1'b1;
      rd_m_d    = rd_q;
    end
  end

  assign StallE = md_start || (state_q == S_BUSY);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      pc4_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      alu_m_q   <= '0;
      wd_m_q    <= '0;
      pc4_m_q   <= '0;
      rd_m_q    <= '0;
      valid_m_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      pc4_q     <= pc4_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      alu_m_q   <= alu_m_d;
      wd_m_q    <= wd_m_d;
      pc4_m_q   <= pc4_m_d;
      rd_m_q    <= rd_m_d;
      valid_m_q <= valid_m_d;
    end
  end

  assign ALUResultM = alu_m_q;
  assign WriteDataM = wd_m_q;
  assign PCPlus4M   = pc4_m_q;
  assign RdM        = rd_m_q;
  assign ValidM     = valid_m_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_stage_md.sv
`default_nettype none
// tb_exec_stage_md -- directed scoreboard bench for exec_stage_md (XLEN 32 and 16)
module tb_exec_stage_md;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ValidE, FlushE, ALUSrcE, MdE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW, ALUResultM_back;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [3:0]  ALUControlE;
  logic [2:0]  MdOpE;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, PCTargetE;
  logic [4:0]  RdM;
  logic        ValidM, ZeroE, StallE;

  exec_stage_md #(.XLEN(32), .MD_EN(1)) u_dut (
    .clk(clk), .rst(rst), .ValidE(ValidE), .FlushE(FlushE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .ResultW(ResultW), .ALUResultM_back(ALUResultM_back),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .MdE(MdE), .MdOpE(MdOpE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .ValidM(ValidM), .PCTargetE(PCTargetE), .ZeroE(ZeroE), .StallE(StallE)
  );

  logic        s_valid, s_md;
  logic [15:0] s_rd1, s_rd2;
  logic [2:0]  s_op;
  logic [15:0] s_alu_m, s_wd_m, s_pc4_m, s_pct;
  logic [4:0]  s_rd_m;
  logic        s_valid_m, s_zero, s_stall;

  exec_stage_md #(.XLEN(16), .MD_EN(1)) u_dut16 (
    .clk(clk), .rst(rst), .ValidE(s_valid), .FlushE(1'b0),
    .RD1E(s_rd1), .RD2E(s_rd2), .PCE(16'h0), .ImmExtE(16'h0), .PCPlus4E(16'h0),
    .RdE(5'd3), .ResultW(16'h0), .ALUResultM_back(16'h0),
    .ForwardAE(2'b00), .ForwardBE(2'b00), .ALUSrcE(1'b0),
    .ALUControlE(4'd0), .MdE(s_md), .MdOpE(s_op),
    .ALUResultM(s_alu_m), .WriteDataM(s_wd_m), .PCPlus4M(s_pc4_m),
    .RdM(s_rd_m), .ValidM(s_valid_m), .PCTargetE(s_pct), .ZeroE(s_zero), .StallE(s_stall)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_validm"}, {63'd0, ValidM}, 64'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_res"}, {32'd0, ALUResultM}, {32'd0, e.res});
      check({tag, "_wd"},  {32'd0, WriteDataM}, {32'd0, e.wd});
      check({tag, "_pc4"}, {32'd0, PCPlus4M},   {32'd0, e.pc4});
      check({tag, "_rd"},  {59'd0, RdM},        {59'd0, e.rd});
    end
  endtask

  task automatic set_alu(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    ALUControlE = ctl; RD1E = a; RD2E = b;
    ForwardAE = 2'b00; ForwardBE = 2'b00; ALUSrcE = 1'b0; MdE = 1'b0;
    RdE = RdE + 5'd1; PCPlus4E = PCPlus4E + 32'd4;
  endtask

  // Drive a one-cycle ALU instruction; expected wd is the forwarded B value.
  task automatic alu_step(input string tag, input logic [31:0] res, input logic [31:0] wd);
    sb.push_back('{res, wd, PCPlus4E, RdE});
    ValidE = 1'b1;
    #1;
    check({tag, "_zero"}, {63'd0, ZeroE}, {63'd0, (res == 32'd0)});
    check({tag, "_nostall"}, {63'd0, StallE}, 64'd0);
    tick();
    ValidE = 1'b0;
    pop_check(tag);
  endtask

  // Issue a mul/div, scramble operands after issue, count stall cycles, check result.
  task automatic md_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int   n;
    logic saw;
    RdE = RdE + 5'd1; PCPlus4E = PCPlus4E + 32'd4;
    ForwardAE = 2'b00; ForwardBE = 2'b00; ALUSrcE = 1'b1; ImmExtE = 32'h0BAD_0BAD;
    MdE = 1'b1; MdOpE = op; RD1E = a; RD2E = b; ValidE = 1'b1;
    sb.push_back('{exp, b, PCPlus4E, RdE});
    #1;
    n = 0; saw = 1'b0;
    while (StallE === 1'b1 && n < 100) begin
      n++;
      tick();
      if (n == 1) begin RD1E = ~a; RD2E = a ^ b ^ 32'h1234; end
      if (ValidM === 1'b1) saw = 1'b1;
    end
    check({tag, "_stall_len"}, n, 64'd33);
    check({tag, "_bubbles"}, {63'd0, saw}, 64'd0);
    tick();
    ValidE = 1'b0; MdE = 1'b0; ALUSrcE = 1'b0;
    pop_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; ValidE = 1'b0; FlushE = 1'b0; ALUSrcE = 1'b0; MdE = 1'b0; MdOpE = 3'd0;
    RD1E = '0; RD2E = '0; PCE = '0; ImmExtE = '0; PCPlus4E = 32'h1000; RdE = 5'd0;
    ResultW = '0; ALUResultM_back = '0; ForwardAE = 2'b00; ForwardBE = 2'b00; ALUControlE = 4'd0;
    s_valid = 1'b0; s_md = 1'b0; s_rd1 = '0; s_rd2 = '0; s_op = 3'd0;
    tick(); tick();
    check("rst_alu",   {32'd0, ALUResultM}, 64'd0);
    check("rst_validm", {63'd0, ValidM}, 64'd0);
    check("rst_rdm",   {59'd0, RdM}, 64'd0);
    check("rst_stall", {63'd0, StallE}, 64'd0);
    rst = 1'b1;
    tick();

    set_alu(4'd0, 32'd5, 32'd7);                alu_step("add", 32'd12, 32'd7);
    set_alu(4'd1, 32'd5, 32'd5);                alu_step("sub_zero", 32'd0, 32'd5);
    set_alu(4'd2, 32'h0000_F0F0, 32'h0000_FF00); alu_step("and", 32'h0000_F000, 32'h0000_FF00);
    set_alu(4'd3, 32'h0000_F0F0, 32'h0000_FF00); alu_step("or", 32'h0000_FFF0, 32'h0000_FF00);
    set_alu(4'd4, 32'h0000_F0F0, 32'h0000_FF00); alu_step("xor", 32'h0000_0FF0, 32'h0000_FF00);
    set_alu(4'd5, 32'hFFFF_FFFF, 32'd1);        alu_step("slt", 32'd1, 32'd1);
    set_alu(4'd6, 32'hFFFF_FFFF, 32'd1);        alu_step("sltu", 32'd0, 32'd1);
    set_alu(4'd7, 32'd1, 32'd33);               alu_step("sll_mask", 32'd2, 32'd33);
    set_alu(4'd8, 32'h8000_0000, 32'd4);        alu_step("srl", 32'h0800_0000, 32'd4);
    set_alu(4'd9, 32'h8000_0000, 32'd4);        alu_step("sra", 32'hF800_0000, 32'd4);
    set_alu(4'd12, 32'd9, 32'd3);               alu_step("op12", 32'd0, 32'd3);

    set_alu(4'd0, 32'd1, 32'd2);
    ForwardAE = 2'b10; ALUResultM_back = 32'h100; ALUSrcE = 1'b1; ImmExtE = 32'hFFFF_FFFC;
    ForwardBE = 2'b01; ResultW = 32'hAA; PCE = 32'h1000;
    #1;
    check("pctarget", {32'd0, PCTargetE}, 64'h0000_0FFC);
    alu_step("fwd_imm", 32'h0000_00FC, 32'h0000_00AA);
    set_alu(4'd0, 32'd55, 32'd66);
    ForwardAE = 2'b11;                          alu_step("fwd_zero", 32'd66, 32'd66);

    set_alu(4'd0, 32'd1, 32'd1);
    RdE = 5'd9; ValidE = 1'b1; FlushE = 1'b1;
    tick();
    FlushE = 1'b0; ValidE = 1'b0;
    check("flushed_validm", {63'd0, ValidM}, 64'd0);
    check("flushed_rdm", {59'd0, RdM}, 64'd0);

    md_op("mul",    3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    md_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    md_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    md_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    md_op("mul_neg", 3'd0, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1);
    md_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    md_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    md_op("divu_z", 3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF);
    md_op("remu_z", 3'd7, 32'd7, 32'd0, 32'd7);
    md_op("div_z_neg", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    md_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    md_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    md_op("rem_negb", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1);
    md_op("divu", 3'd5, 32'd100, 32'd7, 32'd14);

    // Flush in the tenth BUSY cycle
    MdE = 1'b1; MdOpE = 3'd4; RD1E = 32'd100; RD2E = 32'd7; ValidE = 1'b1;
    #1;
    check("flush_issue_stall", {63'd0, StallE}, 64'd1);
    tick();
    repeat (9) tick();
    FlushE = 1'b1;
    #1;
    check("flush_busy_stall", {63'd0, StallE}, 64'd1);
    tick();
    FlushE = 1'b0; ValidE = 1'b0; MdE = 1'b0;
    #1;
    check("flush_stall_drop", {63'd0, StallE}, 64'd0);
    check("flush_validm", {63'd0, ValidM}, 64'd0);
    tick();
    check("flush_validm2", {63'd0, ValidM}, 64'd0);
    set_alu(4'd0, 32'd20, 32'd22);              alu_step("add_after_flush", 32'd42, 32'd22);

    // Reset during BUSY
    MdE = 1'b1; MdOpE = 3'd5; RD1E = 32'd1000; RD2E = 32'd3; ValidE = 1'b1;
    repeat (5) tick();
    rst = 1'b0; ValidE = 1'b0; MdE = 1'b0;
    tick();
    rst = 1'b1;
    check("rstbusy_stall", {63'd0, StallE}, 64'd0);
    check("rstbusy_alu",   {32'd0, ALUResultM}, 64'd0);
    check("rstbusy_wd",    {32'd0, WriteDataM}, 64'd0);
    check("rstbusy_pc4",   {32'd0, PCPlus4M}, 64'd0);
    check("rstbusy_rd",    {59'd0, RdM}, 64'd0);
    check("rstbusy_validm", {63'd0, ValidM}, 64'd0);
    tick();
    check("rstbusy_idle", {63'd0, ValidM}, 64'd0);

    // XLEN = 16 instance
    s_md = 1'b1; s_op = 3'd3; s_rd1 = 16'hFFFF; s_rd2 = 16'hFFFF; s_valid = 1'b1;
    #1;
    n = 0;
    while (s_stall === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("x16_stall_len", n, 64'd17);
    check("x16_pre_validm", {63'd0, s_valid_m}, 64'd0);
    tick();
    s_valid = 1'b0; s_md = 1'b0;
    check("x16_validm", {63'd0, s_valid_m}, 64'd1);
    check("x16_mulhu", {48'd0, s_alu_m}, 64'h0000_0000_0000_FFFE);
    check("x16_rd", {59'd0, s_rd_m}, 64'd3);

    check("sb_drained", sb.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
